// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem request in flight, applies execute redirects.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being force-aligned.
module fetch_sequencer #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_valid_i,
    input  logic [1:0]      pc_source_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] jalr_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        , S_TRAP = 2'd3
`endif
    } state_e;

    localparam logic [1:0]      PCSRC_BRANCH = 2'b01;
    localparam logic [1:0]      PCSRC_JALR   = 2'b10;
    localparam logic [XLEN-1:0] INSTR_BYTES  = XLEN'(4);

    state_e          r_state;
    state_e          w_state_d;
    state_e          w_fault_state;
    logic            r_active;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_d;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] w_req_addr_d;
    logic            r_drop;
    logic            w_drop_d;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] w_instr_d;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] w_instr_pc_d;

    logic            w_redir;
    logic            w_mis;
    logic            w_trap_pend;
    logic            w_resume_trap;
    logic [XLEN-1:0] w_target_raw;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_resume_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            r_trap_pend;
    logic [XLEN-1:0] r_mis_addr;
`endif

    // Taken redirect decode; jalr targets always have bit 0 cleared
    assign w_redir      = redirect_valid_i &&
                          ((pc_source_i == PCSRC_BRANCH) || (pc_source_i == PCSRC_JALR));
    assign w_target_raw = (pc_source_i == PCSRC_JALR) ? (jalr_target_i & ~XLEN'(1))
                                                      : branch_target_i;
    assign w_pc_inc     = r_pc + INSTR_BYTES;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_target      = w_target_raw;
    assign w_mis         = w_redir && (w_target_raw[1:0] != 2'b00);
    assign w_fault_state = S_TRAP;
    assign w_trap_pend   = r_trap_pend;
`else
    assign w_target      = w_target_raw & ~XLEN'(3);
    assign w_mis         = 1'b0;
    assign w_fault_state = S_REQ;
    assign w_trap_pend   = 1'b0;
`endif

    // Where to go once a discarded response drains: latest redirect wins
    assign w_resume_pc   = w_redir ? w_target : r_pc;
    assign w_resume_trap = w_redir ? w_mis : w_trap_pend;

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_req_addr_d = r_req_addr;
        w_drop_d     = r_drop;
        w_instr_d    = r_instr;
        w_instr_pc_d = r_instr_pc;
        case (r_state)
            S_REQ: begin
                if (!r_active) begin
                    // Nothing is presented yet, so a redirect can retarget directly
                    if (w_redir) begin
                        w_pc_d       = w_target;
                        w_req_addr_d = w_target;
                        if (w_mis) begin
                            w_state_d = w_fault_state;
                        end
                    end
                end else begin
                    if (imem_gnt_i) begin
                        w_state_d = S_WAIT;
                    end
                    if (w_redir) begin
                        w_pc_d   = w_target;
                        w_drop_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (r_drop || w_redir) begin
                        w_drop_d     = 1'b0;
                        w_pc_d       = w_resume_pc;
                        w_req_addr_d = w_resume_pc;
                        w_state_d    = w_resume_trap ? w_fault_state : S_REQ;
                    end else begin
                        w_instr_d    = imem_rdata_i;
                        w_instr_pc_d = r_req_addr;
                        w_state_d    = S_HOLD;
                    end
                end else if (w_redir) begin
                    w_pc_d   = w_target;
                    w_drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                // A redirect squashes the held word and overrides the sequential pc+4
                if (w_redir) begin
                    w_pc_d       = w_target;
                    w_req_addr_d = w_target;
                    w_state_d    = w_mis ? w_fault_state : S_REQ;
                end else if (instr_ready_i) begin
                    w_pc_d       = w_pc_inc;
                    w_req_addr_d = w_pc_inc;
                    w_state_d    = S_REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                if (w_redir && !w_mis) begin
                    w_pc_d       = w_target;
                    w_req_addr_d = w_target;
                    w_state_d    = S_REQ;
                end
            end
`endif
            default: begin
                w_state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_REQ;
            r_active   <= 1'b0;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_drop     <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_state_d;
            r_active   <= 1'b1;
            r_pc       <= w_pc_d;
            r_req_addr <= w_req_addr_d;
            r_drop     <= w_drop_d;
            r_instr    <= w_instr_d;
            r_instr_pc <= w_instr_pc_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Pending-trap flag rides along with the drop flag; offending address tracks the latest bad target
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_trap_pend <= 1'b0;
            r_mis_addr  <= '0;
        end else begin
            r_trap_pend <= w_drop_d ? (w_redir ? w_mis : r_trap_pend) : 1'b0;
            if (w_mis) begin
                r_mis_addr <= w_target;
            end
        end
    end

    assign misalign_o      = (r_state == S_TRAP);
    assign misalign_addr_o = r_mis_addr;
`else
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

    assign imem_req_o    = r_active && (r_state == S_REQ);
    assign imem_addr_o   = r_req_addr;
    assign instr_valid_o = (r_state == S_HOLD);
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected grants and delivered words are queued, a monitor compares.
module tb_fetch_sequencer;

    logic        clk_i;
    logic        rst_ni;
    logic        redirect_valid_i;
    logic [1:0]  pc_source_i;
    logic [31:0] branch_target_i;
    logic [31:0] jalr_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    logic [31:0] q_req[$];
    logic [31:0] q_instr[$];
    int          n_checks;
    int          n_errs;
    int          gnt_delay;
    int          cyc;
    logic [31:0] pend;

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .redirect_valid_i (redirect_valid_i),
        .pc_source_i      (pc_source_i),
        .branch_target_i  (branch_target_i),
        .jalr_target_i    (jalr_target_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_ready_i    (instr_ready_i),
        .misalign_o       (misalign_o),
        .misalign_addr_o  (misalign_addr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: grants after gnt_delay waiting cycles, responds one cycle after the grant
    initial begin
        logic [31:0] gaddr;
        int          cnt;
        gaddr         = '0;
        cnt           = 0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            imem_rvalid_i = imem_gnt_i;
            imem_rdata_i  = imem_gnt_i ? mem_word(gaddr) : 32'h0;
            imem_gnt_i    = 1'b0;
            if (imem_req_o) begin
                if (cnt >= gnt_delay) begin
                    imem_gnt_i = 1'b1;
                    gaddr      = imem_addr_o;
                    cnt        = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: grants and accepted instructions are popped from the scoreboard queues
    initial begin
        logic        prev_valid;
        int          last_gnt;
        logic [31:0] e;
        prev_valid = 1'b0;
        last_gnt   = 0;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (imem_req_o && imem_gnt_i) begin
                    if (q_req.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL req_unexpected: got 0x%08h expected none", imem_addr_o);
                    end else begin
                        e = q_req.pop_front();
                        check("req_addr", imem_addr_o, e);
                    end
                    last_gnt = cyc;
                end
                if (instr_valid_o && !prev_valid) begin
                    check("valid_latency", 32'(cyc - last_gnt), 32'd2);
                end
                if (instr_valid_o && instr_ready_i) begin
                    if (q_instr.size() == 0) begin
                        n_checks++;
                        n_errs++;
                        $display("FAIL instr_unexpected: got pc 0x%08h expected none", instr_pc_o);
                    end else begin
                        e = q_instr.pop_front();
                        check("instr_pc", instr_pc_o, e);
                        check("instr_data", instr_o, mem_word(e));
                    end
                end
                prev_valid = instr_valid_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic redirect(input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt);
        redirect_valid_i = 1'b1;
        pc_source_i      = src;
        branch_target_i  = bt;
        jalr_target_i    = jt;
        tick();
        redirect_valid_i = 1'b0;
        pc_source_i      = 2'b00;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!instr_valid_o && k < 50) begin
            tick();
            k++;
        end
        n_checks++;
        if (!instr_valid_o) begin
            n_errs++;
            $display("FAIL %s: got valid=0 expected valid=1 within 50 cycles", name);
        end
    endtask

    // Run until every queued instruction is consumed, then stall further grants
    task automatic drain(input string name, input bit noise);
        int k;
        bit done;
        k    = 0;
        done = 1'b0;
        while (!done && k < 200) begin
            @(posedge clk_i);
            if (q_instr.size() == 0) begin
                gnt_delay = 1000;
                done      = 1'b1;
            end
            #1;
            if (!done && noise) begin
                redirect_valid_i = 1'b1;
                pc_source_i      = (k % 2 == 0) ? 2'b00 : 2'b11;
                branch_target_i  = 32'h0000_0300;
                jalr_target_i    = 32'h0000_0401;
            end
            k++;
        end
        redirect_valid_i = 1'b0;
        pc_source_i      = 2'b00;
        n_checks++;
        if (!done) begin
            n_errs++;
            $display("FAIL %s: got %0d pending expected 0 within 200 cycles", name, q_instr.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks         = 0;
        n_errs           = 0;
        gnt_delay        = 0;
        rst_ni           = 1'b0;
        instr_ready_i    = 1'b0;
        redirect_valid_i = 1'b0;
        pc_source_i      = 2'b00;
        branch_target_i  = '0;
        jalr_target_i    = '0;
        repeat (3) tick();

        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_instr_pc", instr_pc_o, 32'h0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        check("rst_misalign_addr", misalign_addr_o, 32'h0);

        // Sequential stream, immediate grants, ready held high
        q_req.push_back(32'h0);  q_req.push_back(32'h4);  q_req.push_back(32'h8);
        q_instr.push_back(32'h0); q_instr.push_back(32'h4); q_instr.push_back(32'h8);
        instr_ready_i = 1'b1;
        rst_ni        = 1'b1;
        check("req_low_release", 32'(imem_req_o), 32'd0);
        tick();
        check("req_first", 32'(imem_req_o), 32'd1);
        check("addr_first", imem_addr_o, 32'h0);
        drain("seq_drain", 1'b0);

        // Delayed grant with a branch redirect while the request is still presented
        instr_ready_i = 1'b0;
        gnt_delay     = 3;
        q_req.push_back(32'hC);
        q_req.push_back(32'h100);
        check("req_c", 32'(imem_req_o), 32'd1);
        check("addr_c", imem_addr_o, 32'hC);
        tick();
        redirect(2'b01, 32'h0000_0100, 32'h0);
        check("req_stable", 32'(imem_req_o), 32'd1);
        check("addr_stable", imem_addr_o, 32'hC);
        wait_valid("wait_100");
        check("hold_pc_100", instr_pc_o, 32'h100);
        check("hold_data_100", instr_o, mem_word(32'h100));

        // Stalled decode, then jalr redirect squashes the held word
        repeat (5) tick();
        check("hold_still_valid", 32'(instr_valid_o), 32'd1);
        q_req.push_back(32'h204);
        redirect(2'b10, 32'h0, 32'h0000_0205);
        gnt_delay = 0;
        check("jalr_req", 32'(imem_req_o), 32'd1);
        check("jalr_addr", imem_addr_o, 32'h204);
        check("jalr_squash", 32'(instr_valid_o), 32'd0);
        check("jalr_misalign", 32'(misalign_o), 32'd0);
        wait_valid("wait_204");

        // Redirect racing with ready in the same HOLD cycle
        q_req.push_back(32'h40);
        redirect(2'b01, 32'h0000_0040, 32'h0);
        wait_valid("wait_40");
        check("hold_pc_40", instr_pc_o, 32'h40);
        q_instr.push_back(32'h40);
        q_req.push_back(32'h80);   q_req.push_back(32'h84);   q_req.push_back(32'h88);
        q_instr.push_back(32'h80); q_instr.push_back(32'h84); q_instr.push_back(32'h88);
        instr_ready_i = 1'b1;
        redirect(2'b01, 32'h0000_0080, 32'h0);
        check("race_req", 32'(imem_req_o), 32'd1);
        check("race_addr", imem_addr_o, 32'h80);

        // Sources 00 and 11 must leave the sequential stream alone
        drain("ignored_src_drain", 1'b1);

`ifdef FETCH_MISALIGN_TRAP_EN
        q_req.push_back(32'h8C);
        redirect(2'b01, 32'h0000_0102, 32'h0);
        gnt_delay = 0;
        begin
            int k;
            k = 0;
            while (!misalign_o && k < 20) begin
                tick();
                k++;
            end
        end
        check("trap_misalign", 32'(misalign_o), 32'd1);
        check("trap_addr", misalign_addr_o, 32'h102);
        check("trap_no_req", 32'(imem_req_o), 32'd0);
        check("trap_no_valid", 32'(instr_valid_o), 32'd0);
        repeat (3) tick();
        check("trap_no_req_later", 32'(imem_req_o), 32'd0);
        q_req.push_back(32'h200);
        q_instr.push_back(32'h200);
        redirect(2'b01, 32'h0000_0200, 32'h0);
        check("trap_exit_req", 32'(imem_req_o), 32'd1);
        check("trap_exit_addr", imem_addr_o, 32'h200);
        check("trap_exit_misalign", 32'(misalign_o), 32'd0);
        drain("trap_exit_drain", 1'b0);
        pend = 32'h204;
`else
        q_req.push_back(32'h8C);
        q_req.push_back(32'h100);
        q_instr.push_back(32'h100);
        redirect(2'b01, 32'h0000_0102, 32'h0);
        gnt_delay = 0;
        drain("align_drain", 1'b0);
        check("align_misalign", 32'(misalign_o), 32'd0);
        check("align_misalign_addr", misalign_addr_o, 32'h0);
        pend = 32'h104;
`endif

        // Address wrap from the top of the space
        q_req.push_back(pend);
        q_req.push_back(32'hFFFF_FFFC);
        q_req.push_back(32'h0);
        q_instr.push_back(32'hFFFF_FFFC);
        q_instr.push_back(32'h0);
        redirect(2'b01, 32'hFFFF_FFFC, 32'h0);
        gnt_delay = 0;
        drain("wrap_drain", 1'b0);
        tick();
        check("final_addr", imem_addr_o, 32'h4);
        check("q_req_empty", 32'(q_req.size()), 32'd0);
        check("q_instr_empty", 32'(q_instr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
